// File: rtl/lsosc_ctrl.sv
// lsosc_ctrl: power sequencer and share controller for the low-speed oscillator.
// Requesters ask for the LF clock with level requests; the block powers the
// oscillator up, waits out the settling window with enable low, enables it,
// and after the last request drops holds it for a while before shutting down.
module lsosc_ctrl #(
    parameter int NUM_REQ        = 3,
    parameter int STARTUP_CYCLES = 4800,
    parameter int IDLE_HOLD      = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               lsosc_pu,
    output logic               lsosc_en,
    output logic               lf_ready,
    output logic [2:0]         state
);

    localparam int MAXC = (STARTUP_CYCLES > IDLE_HOLD) ? STARTUP_CYCLES : IDLE_HOLD;
    localparam int CW   = $clog2(MAXC + 1);

    // Load values are one less than the window: the loading edge counts as the first cycle.
    localparam logic [CW-1:0] START_LD = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD  = (IDLE_HOLD > 0) ? CW'(IDLE_HOLD - 1) : '0;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWRUP = 3'd1,
        S_ON    = 3'd2,
        S_HOLD  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_pu, r_en;
    logic            w_pu_nxt, w_en_nxt;
    logic            w_any_req;

    assign w_any_req = |req;

    // Next-state, counter and next-output decode; pins are registered from the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pu_nxt    = 1'b0;
        w_en_nxt    = 1'b0;

        case (r_state)
            S_OFF: begin
                if (w_any_req) begin
                    w_state_nxt = S_PWRUP;
                    w_cnt_nxt   = START_LD;
                end
            end
            S_PWRUP: begin
                // A dropped request aborts settling; the count restarts from scratch next time.
                if (!w_any_req)          w_state_nxt = S_OFF;
                else if (r_cnt == '0)    w_state_nxt = S_ON;
                else                     w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_ON: begin
                if (!w_any_req) begin
                    if (IDLE_HOLD > 0) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = IDLE_LD;
                    end else begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_HOLD: begin
                // Oscillator is still running, so a returning request needs no re-settling.
                if (w_any_req)           w_state_nxt = S_ON;
                else if (r_cnt == '0)    w_state_nxt = S_STOP;
                else                     w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_STOP: begin
                // One cycle with enable low before power drops; pending requests restart from OFF.
                w_state_nxt = S_OFF;
            end
            default: begin
                w_state_nxt = S_OFF;
                w_cnt_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            S_PWRUP: begin w_pu_nxt = 1'b1; w_en_nxt = 1'b0; end
            S_ON:    begin w_pu_nxt = 1'b1; w_en_nxt = 1'b1; end
            S_HOLD:  begin w_pu_nxt = 1'b1; w_en_nxt = 1'b1; end
            S_STOP:  begin w_pu_nxt = 1'b1; w_en_nxt = 1'b0; end
            default: begin w_pu_nxt = 1'b0; w_en_nxt = 1'b0; end
        endcase
    end

    // State, counter and oscillator pin registers; reset forces everything off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_pu    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pu    <= w_pu_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign lsosc_pu = r_pu;
    assign lsosc_en = r_en;
    assign lf_ready = r_en;
    assign state    = r_state;
    assign ack      = req & {NUM_REQ{r_en}};

endmodule

// File: tb/tb_lsosc_ctrl.sv
// tb_lsosc_ctrl: directed test-plan scenarios plus randomized request traffic,
// checked every cycle against a timeline-based reference model.
module tb_lsosc_ctrl;

    localparam int NR = 3;
    localparam int SC = 10;
    localparam int IH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] ack;
    logic          lsosc_pu, lsosc_en, lf_ready;
    logic [2:0]    state;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: oscillator condition tracked as powered/enabled flags plus
    // elapsed-time counters for the settling and idle windows.
    int m_pu = 0, m_en = 0, m_stop = 0, m_hold = 0, m_set = 0, m_idle = 0;

    lsosc_ctrl #(.NUM_REQ(NR), .STARTUP_CYCLES(SC), .IDLE_HOLD(IH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .lsosc_pu (lsosc_pu),
        .lsosc_en (lsosc_en),
        .lf_ready (lf_ready),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (m_pu == 0)  return 0;
        if (m_stop)     return 4;
        if (m_en == 0)  return 1;
        if (m_hold)     return 3;
        return 2;
    endfunction

    // Advance the model by one clock edge with the sampled request and reset.
    task automatic model_step(input logic [NR-1:0] r, input logic rs);
        bit any;
        any = |r;
        if (rs) begin
            m_pu = 0; m_en = 0; m_stop = 0; m_hold = 0;
        end else if (m_stop) begin
            m_stop = 0; m_pu = 0;
        end else if (m_pu == 0) begin
            if (any) begin m_pu = 1; m_set = 1; end
        end else if (m_en == 0) begin
            if (!any)             m_pu = 0;
            else if (m_set == SC) m_en = 1;
            else                  m_set++;
        end else if (any) begin
            m_hold = 0;
        end else if (!m_hold) begin
            if (IH == 0) begin m_en = 0; m_stop = 1; end
            else begin m_hold = 1; m_idle = 1; end
        end else if (m_idle == IH) begin
            m_en = 0; m_stop = 1; m_hold = 0;
        end else begin
            m_idle++;
        end
    endtask

    // One cycle: drive at negedge, check combinational ack, clock, then check all outputs.
    task automatic cyc(input logic [NR-1:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        #1;
        chk("ack_comb", ack, r & {NR{m_en[0]}});
        @(posedge clk);
        model_step(r, rs);
        #1;
        chk("state", state, m_state());
        chk("pu", lsosc_pu, m_pu);
        chk("en", lsosc_en, m_en);
        chk("ready", lf_ready, m_en);
        chk("ack", ack, r & {NR{m_en[0]}});
    endtask

    task automatic run(input logic [NR-1:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(r, 1'b0);
    endtask

    initial begin
        logic [NR-1:0] rr;
        int len;

        // Reset state
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        chk("rst_state", state, 0);
        chk("rst_pu", lsosc_pu, 0);
        chk("rst_ack", ack, 0);
        run('0, 2);

        // Cold start: pu after edge 0, en after edge 10
        cyc(3'b001, 1'b0);
        chk("cold_pu0", lsosc_pu, 1);
        chk("cold_en0", lsosc_en, 0);
        for (int e = 1; e <= 9; e++) begin
            cyc(3'b001, 1'b0);
            chk("cold_en_lo", lsosc_en, 0);
        end
        cyc(3'b001, 1'b0);
        chk("cold_en10", lsosc_en, 1);
        chk("cold_ack10", ack, 3'b001);
        run(3'b001, 9);                  // edges 11..19
        // Shutdown: drop at edge 20
        cyc('0, 1'b0);
        chk("shut_hold", state, 3);
        run('0, 4);                      // edges 21..24
        chk("shut_en24", lsosc_en, 1);
        cyc('0, 1'b0);                   // edge 25
        chk("shut_stop", state, 4);
        chk("shut_stop_en", lsosc_en, 0);
        chk("shut_stop_pu", lsosc_pu, 1);
        cyc('0, 1'b0);                   // edge 26
        chk("shut_off", state, 0);
        chk("shut_off_pu", lsosc_pu, 0);

        // Re-request in HOLD
        run(3'b001, 12);
        run('0, 2);
        cyc(3'b100, 1'b0);
        chk("hold_rereq_on", state, 2);
        chk("hold_rereq_en", lsosc_en, 1);
        run(3'b100, 3);
        run('0, 8);

        // Abort during PWRUP, then re-request at edge 6
        run(3'b010, 4);                  // edges 0..3
        cyc('0, 1'b0);                   // edge 4
        chk("abort_off", state, 0);
        cyc('0, 1'b0);                   // edge 5
        run(3'b010, 10);                 // edges 6..15
        chk("abort_en15", lsosc_en, 0);
        cyc(3'b010, 1'b0);               // edge 16
        chk("abort_en16", lsosc_en, 1);

        // Overlapping requesters
        run(3'b011, 3);
        run(3'b010, 4);
        chk("overlap_on", state, 2);
        cyc('0, 1'b0);
        chk("overlap_hold", state, 3);
        run('0, 6);

        // Reset while ON with request held
        run(3'b001, 12);
        cyc(3'b001, 1'b1);
        chk("rst_on_state", state, 0);
        chk("rst_on_pu", lsosc_pu, 0);
        cyc(3'b001, 1'b0);
        chk("rst_pwrup", state, 1);
        run(3'b001, 9);
        chk("rst_settle_en", lsosc_en, 0);
        cyc(3'b001, 1'b0);
        chk("rst_settle_done", lsosc_en, 1);
        run('0, 8);

        // Randomized traffic: request patterns held for random run lengths
        for (int k = 0; k < 150; k++) begin
            rr  = NR'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) rr = '0;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++)
                cyc(rr, ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
